// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit in front of a word-organised data memory.
// Optional alignment trap enabled by defining MISALIGN_TRAP_EN.
module load_store_unit #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        busy,
    output logic        done,
    output logic        misaligned
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic            op_store;
    logic [2:0]      f3_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic            mis_q;
    logic [31:0]     mem [DEPTH];

    logic            req, accept, last, commit_wr, commit_rd;
    logic [1:0]      sz;
    logic [AW-1:0]   idx;
    logic [3:0]      be;
    logic [31:0]     wword, rword, ld_val;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic            unused_addr_bits;

    // Returns {half, byte}; anything else is a word access.
    function automatic logic [1:0] access_size(input logic store, input logic [2:0] f3);
        if (store) return {f3 == 3'b001, f3 == 3'b000};
        return {f3[1:0] == 2'b01, f3[1:0] == 2'b00};
    endfunction

    assign unused_addr_bits = &{1'b0, address[31:AW+2]};

    assign req       = memRead | memWrite;
    assign accept    = (state == IDLE) && req;
    assign last      = (cnt == CW'(LATENCY - 1));
    assign busy      = accept || (state == ACCESS);
    assign commit_wr = (state == ACCESS) && last && !mis_q && op_store;
    assign commit_rd = (state == ACCESS) && last && !mis_q && !op_store;

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = ACCESS;
            ACCESS:  if (last || mis_q) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            done     <= 1'b0;
            readData <= '0;
            op_store <= 1'b0;
            f3_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state <= state_next;
            done  <= (state_next == DONE);
            if (accept) begin
                op_store <= memWrite;
                f3_q     <= funct3;
                addr_q   <= address[AW+1:0];
                wdata_q  <= writeData;
                cnt      <= '0;
            end else if (state == ACCESS && !last) begin
                cnt <= cnt + CW'(1);
            end
            if (commit_rd) readData <= ld_val;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic [1:0] sz_in;
    logic       mis_det;

    assign sz_in   = access_size(memWrite, funct3);
    assign mis_det = (sz_in[1] && address[0]) || (sz_in == 2'b00 && address[1:0] != 2'b00);

    // A trapped request spends one cycle in ACCESS without touching memory.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mis_q      <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            if (accept) mis_q <= mis_det;
            misaligned <= (state_next == DONE) && mis_q;
        end
    end
`else
    assign mis_q      = 1'b0;
    assign misaligned = 1'b0;
`endif

    // Byte-lane write enables; sub-size address bits select the lane.
    assign sz  = access_size(op_store, f3_q);
    assign idx = addr_q[AW+1:2];

    always_comb begin
        be    = 4'b1111;
        wword = wdata_q;
        if (sz[0]) begin
            be    = 4'b0001 << addr_q[1:0];
            wword = {4{wdata_q[7:0]}};
        end else if (sz[1]) begin
            be    = addr_q[1] ? 4'b1100 : 4'b0011;
            wword = {2{wdata_q[15:0]}};
        end
    end

    assign rword   = mem[idx];
    assign ld_byte = rword[{addr_q[1:0], 3'b000} +: 8];
    assign ld_half = rword[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        ld_val = rword;
        case (f3_q)
            3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_val = {24'h0, ld_byte};
            3'b101:  ld_val = {16'h0, ld_half};
            default: ld_val = rword;
        endcase
    end

    // Memory array keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (commit_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

endmodule
